// File: rtl/imm_ext_pipe.sv
// Immediate extension stage: decodes a raw immediate by mode and buffers
// the extended result in a 2-entry FIFO with valid/ready handshakes.
module imm_ext_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SH_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [IN_W-1:0]  i_in,
  input  logic [2:0]       i_mode,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_out_ext,
  output logic             o_mode_err
);

  localparam int unsigned PAD_W   = OUT_W - IN_W;
  localparam int unsigned SHPAD_W = OUT_W - SH_W;

  localparam logic [2:0] MODE_ZERO   = 3'd0;
  localparam logic [2:0] MODE_SIGN   = 3'd1;
  localparam logic [2:0] MODE_LUI    = 3'd2;
  localparam logic [2:0] MODE_BRANCH = 3'd3;
  localparam logic [2:0] MODE_SHAMT  = 3'd4;

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext_d;
  logic             err_d;

  logic [OUT_W-1:0] data_q [2];
  logic             err_q  [2];
  logic             wptr;
  logic             rptr;
  logic [1:0]       count;

  logic push;
  logic pop;

  // Mode decode of the incoming immediate; reserved modes flag an error.
  always_comb begin
    ext_d    = '0;
    err_d    = 1'b0;
    sign_ext = {{PAD_W{i_in[IN_W-1]}}, i_in};
    case (i_mode)
      MODE_ZERO:   ext_d = {{PAD_W{1'b0}}, i_in};
      MODE_SIGN:   ext_d = sign_ext;
      MODE_LUI:    ext_d = {i_in, {PAD_W{1'b0}}};
      MODE_BRANCH: ext_d = sign_ext << 2;
      MODE_SHAMT:  ext_d = {{SHPAD_W{1'b0}}, i_in[SH_W-1:0]};
      default:     err_d = 1'b1;
    endcase
  end

  assign o_valid = (count != 2'd0);
  // A full FIFO refuses pushes even when the head is popped this cycle.
  assign o_ready = (count != 2'd2) && !i_rst;
  assign push    = i_valid && o_ready && !i_flush;
  assign pop     = o_valid && i_ready && !i_flush;

  // Storage, pointers and occupancy; flush beats any same-cycle push/pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count     <= 2'd0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      err_q[0]  <= 1'b0;
      err_q[1]  <= 1'b0;
    end else if (i_flush) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (push) begin
        data_q[wptr] <= ext_d;
        err_q[wptr]  <= err_d;
        wptr         <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head outputs are forced to zero while nothing is buffered.
  assign o_out_ext  = o_valid ? data_q[rptr] : '0;
  assign o_mode_err = o_valid ? err_q[rptr]  : 1'b0;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe (IN_W=16, OUT_W=32, SH_W=5) with a
// push-order scoreboard plus per-scenario directed checks.
module tb_imm_ext_pipe;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_in;
  logic [2:0]  i_mode;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_out_ext;
  logic        o_mode_err;

  int total;
  int bad;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb[$];

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .SH_W(5)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_in       (i_in),
    .i_mode     (i_mode),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_out_ext  (o_out_ext),
    .o_mode_err (o_mode_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic exp_t model(input logic [15:0] v, input logic [2:0] m);
    exp_t r;
    logic signed [31:0] s;
    s   = $signed(v);
    r.e = 1'b0;
    case (m)
      3'd0:    r.d = 32'(v);
      3'd1:    r.d = s;
      3'd2:    r.d = 32'(v) * 32'd65536;
      3'd3:    r.d = s * 4;
      3'd4:    r.d = 32'(v) & 32'h1F;
      default: begin r.d = 32'h0; r.e = 1'b1; end
    endcase
    return r;
  endfunction

  // Scoreboard: compare head each cycle, then apply the handshakes seen.
  always @(negedge i_clk) begin
    if (i_rst) begin
      sb.delete();
    end else begin
      total++;
      if (o_valid !== (sb.size() != 0)) begin
        bad++; $display("FAIL sb_valid got=%b want=%b", o_valid, sb.size() != 0);
      end
      total++;
      if (o_ready !== (sb.size() < 2)) begin
        bad++; $display("FAIL sb_ready got=%b want=%b", o_ready, sb.size() < 2);
      end
      total++;
      if (sb.size() != 0) begin
        if (o_out_ext !== sb[0].d || o_mode_err !== sb[0].e) begin
          bad++; $display("FAIL sb_head got=%h/%b want=%h/%b", o_out_ext, o_mode_err, sb[0].d, sb[0].e);
        end
      end else if (o_out_ext !== 32'h0 || o_mode_err !== 1'b0) begin
        bad++; $display("FAIL sb_idle got=%h/%b want=0/0", o_out_ext, o_mode_err);
      end
      if (i_flush) begin
        sb.delete();
      end else begin
        if (o_valid && i_ready && sb.size() != 0) void'(sb.pop_front());
        if (i_valid && o_ready) sb.push_back(model(i_in, i_mode));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_in = '0; i_mode = '0; i_flush = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_out_ext !== 32'h0 || o_mode_err !== 1'b0) begin
      bad++; $display("FAIL reset_outs got=%b%b%h%b want=0000", o_valid, o_ready, o_out_ext, o_mode_err);
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", o_ready); end
  endtask

  task automatic test_mode_sweep();
    logic [31:0] want [5];
    want[0] = 32'h00008004; want[1] = 32'hFFFF8004; want[2] = 32'h80040000;
    want[3] = 32'hFFFE0010; want[4] = 32'h00000004;
    i_ready = 1'b1;
    for (int m = 0; m < 5; m++) begin
      i_valid = 1'b1; i_in = 16'h8004; i_mode = 3'(m);
      tick();
      total++;
      if (o_valid !== 1'b1 || o_out_ext !== want[m] || o_mode_err !== 1'b0) begin
        bad++; $display("FAIL sweep_mode%0d got=%b/%h/%b want=1/%h/0", m, o_valid, o_out_ext, o_mode_err, want[m]);
      end
    end
    i_valid = 1'b0;
    tick();
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL sweep_drain got=%b want=0", o_valid); end
  endtask

  task automatic test_reserved();
    i_ready = 1'b1; i_valid = 1'b1; i_in = 16'h1234; i_mode = 3'd6;
    tick();
    i_valid = 1'b0;
    total++;
    if (o_valid !== 1'b1 || o_out_ext !== 32'h0 || o_mode_err !== 1'b1) begin
      bad++; $display("FAIL reserved got=%b/%h/%b want=1/0/1", o_valid, o_out_ext, o_mode_err);
    end
    tick();
    total++;
    if (o_valid !== 1'b0 || o_mode_err !== 1'b0) begin
      bad++; $display("FAIL reserved_once got=%b/%b want=0/0", o_valid, o_mode_err);
    end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0; i_mode = 3'd1;
    i_valid = 1'b1; i_in = 16'h0001; tick();
    i_in = 16'h0002; tick();
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", o_ready); end
    i_in = 16'h0003; tick();
    total++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_out_ext !== 32'h1) begin
      bad++; $display("FAIL bp_hold got=%b/%b/%h want=0/1/00000001", o_ready, o_valid, o_out_ext);
    end
    i_ready = 1'b1; tick();
    total++;
    if (o_out_ext !== 32'h2 || o_ready !== 1'b1) begin
      bad++; $display("FAIL bp_out2 got=%h/%b want=00000002/1", o_out_ext, o_ready);
    end
    tick();
    i_valid = 1'b0;
    total++;
    if (o_out_ext !== 32'h3 || o_valid !== 1'b1) begin
      bad++; $display("FAIL bp_out3 got=%h/%b want=00000003/1", o_out_ext, o_valid);
    end
    tick();
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", o_valid); end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1; i_mode = 3'd0; i_valid = 1'b1; i_in = 16'd0;
    tick();
    for (int k = 1; k <= 10; k++) begin
      total++;
      if (o_valid !== 1'b1 || o_out_ext !== 32'(k - 1)) begin
        bad++; $display("FAIL b2b_%0d got=%b/%h want=1/%h", k - 1, o_valid, o_out_ext, 32'(k - 1));
      end
      if (k == 10) i_valid = 1'b0;
      else i_in = 16'(k);
      tick();
    end
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", o_valid); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0; i_mode = 3'd0; i_valid = 1'b1;
    i_in = 16'h00AA; tick();
    i_in = 16'h00BB; tick();
    i_in = 16'h00CC; i_flush = 1'b1; tick();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_out_ext !== 32'h0) begin
      bad++; $display("FAIL flush got=%b/%b/%h want=0/1/0", o_valid, o_ready, o_out_ext);
    end
    tick();
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%b/%h want=0", o_valid, o_out_ext); end
  endtask

  task automatic test_reset_pulse();
    i_ready = 1'b0; i_mode = 3'd0; i_valid = 1'b1;
    i_in = 16'h0011; tick();
    i_in = 16'h0022; tick();
    i_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_out_ext !== 32'h0 || o_ready !== 1'b0 || o_mode_err !== 1'b0) begin
      bad++; $display("FAIL rst_pulse got=%b/%h/%b want=0/0/0", o_valid, o_out_ext, o_ready);
    end
    i_rst = 1'b0;
    sb.delete();
    i_ready = 1'b1; i_valid = 1'b1; i_in = 16'h0055;
    tick();
    i_valid = 1'b0;
    total++;
    if (o_valid !== 1'b1 || o_out_ext !== 32'h55) begin
      bad++; $display("FAIL rst_after_push got=%b/%h want=1/00000055", o_valid, o_out_ext);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mode_sweep();
    test_reserved();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_pulse();
    repeat (2) tick();
    total++;
    if (sb.size() != 0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL final_empty got=%0d/%b want=0/0", sb.size(), o_valid);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
